// File: rtl/block_fetch44_if.sv
// Bus bundle for block_fetch44: fetch request, frame-memory read port and row-word output.
// master is the fetch block's view; slave is the controller/memory/bank side.
interface block_fetch44_if #(
  parameter int WORD_WIDETH = 8,
  parameter int ADDR_WIDTH  = 12
);
  logic                     start;
  logic [7:0]               blk_x;
  logic [7:0]               blk_y;
  logic                     hold;
  logic                     mem_rd;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [WORD_WIDETH*4-1:0] mem_rdata;
  logic [WORD_WIDETH*4-1:0] out_row;
  logic                     out_en;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, blk_x, blk_y, hold, mem_rdata,
    output mem_rd, mem_addr, out_row, out_en, busy, done
  );

  modport slave (
    output start, blk_x, blk_y, hold, mem_rdata,
    input  mem_rd, mem_addr, out_row, out_en, busy, done
  );
endinterface

// File: rtl/block_fetch44.sv
// Fetches one 4x4 pixel block from frame word memory and streams it out as four row words.
// Reads are issued in row order; data returns one cycle later and is registered onto out_row.
module block_fetch44 #(
  parameter int WORD_WIDETH = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int LINE_WORDS  = 16
) (
  input  logic            clk,
  input  logic            rst,
  block_fetch44_if.master bus
);

  localparam int ROW_W = WORD_WIDETH * 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [7:0]            blk_x_q;
  logic [7:0]            blk_y_q;
  logic [1:0]            row;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic                  rd_d1;
  logic                  last_d1;
  logic [ROW_W-1:0]      out_row_q;
  logic                  out_en_q;
  logic                  done_q;

  // Full-width line arithmetic; the cast truncates, so overflow wraps silently.
  assign row_addr = ADDR_WIDTH'((32'(blk_y_q) * 32'd4 + 32'(row)) * 32'(LINE_WORDS)
                                + 32'(blk_x_q));

  assign issue        = (state == ST_ISSUE) && !bus.hold;
  assign bus.mem_rd   = issue;
  assign bus.mem_addr = issue ? row_addr : '0;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.out_row  = out_row_q;
  assign bus.out_en   = out_en_q;
  assign bus.done     = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      blk_x_q <= '0;
      blk_y_q <= '0;
      row     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_ISSUE;
            blk_x_q <= bus.blk_x;
            blk_y_q <= bus.blk_y;
            row     <= '0;
          end
        end
        ST_ISSUE: begin
          if (!bus.hold) begin
            if (row == 2'd3) begin
              state <= ST_DRAIN;
            end else begin
              row <= row + 2'd1;
            end
          end
        end
        ST_DRAIN: begin
          // done_q marks the cycle row 3 is on out_en; leave on that edge.
          if (done_q) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Two-stage strobe pipeline follows each read to its output slot; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_d1     <= 1'b0;
      last_d1   <= 1'b0;
      out_en_q  <= 1'b0;
      done_q    <= 1'b0;
      out_row_q <= '0;
    end else begin
      rd_d1    <= issue;
      last_d1  <= issue && (row == 2'd3);
      out_en_q <= rd_d1;
      done_q   <= rd_d1 && last_d1;
      if (rd_d1) begin
        out_row_q <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_block_fetch44.sv
// Bench for block_fetch44: a queue-based model of issued reads is compared every cycle,
// and directed scenarios are pinned with hand-computed address/cycle lists.
module tb_block_fetch44;

  localparam int LW = 16;
  localparam int AW = 12;

  typedef struct {
    int due;
    int data;
    bit last;
  } rd_t;

  logic clk = 1'b0;
  logic rst;

  block_fetch44_if #(.WORD_WIDETH(8), .ADDR_WIDTH(AW)) bus();

  block_fetch44 #(.WORD_WIDETH(8), .ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Frame memory returns its own word address, one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= 32'(bus.mem_addr);
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  bit  m_active = 0;
  int  m_x = 0;
  int  m_y = 0;
  int  m_issued = 0;
  int  m_row = 0;
  rd_t q[$];
  rd_t item;
  bit  was_active;

  int rd_log[$], addr_log[$], en_log[$], row_log[$], done_log[$];
  int e_a[$], e_b[$], e_c[$], e_d[$];

  bit exp_rd, exp_en, exp_done;
  int exp_addr, exp_row;

  function automatic int modelAddr(int x, int y, int r);
    return ((y * 4 + r) * LW + x) % (1 << AW);
  endfunction

  function automatic string listStr(input int v[$]);
    string s = "{";
    foreach (v[i]) s = {s, $sformatf("%0d%s", v[i], (i == v.size() - 1) ? "" : ",")};
    return {s, "}"};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic checkList(input string name, input int got[$], input int exp[$]);
    bit ok;
    checks++;
    ok = (got.size() == exp.size());
    if (ok) foreach (exp[i]) if (got[i] != exp[i]) ok = 0;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s got=%s want=%s", name, listStr(got), listStr(exp));
    end
  endtask

  task automatic applyStimulus(input bit st, input int x, input int y, input bit h);
    bus.start = st;
    bus.blk_x = 8'(x);
    bus.blk_y = 8'(y);
    bus.hold  = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    rd_log.delete(); addr_log.delete(); en_log.delete(); row_log.delete(); done_log.delete();
    t0 = cyc;
  endtask

  // Model update: each accepted read becomes a queue entry due two cycles after issue.
  always @(posedge clk) begin
    if (rst) begin
      m_active = 0;
      m_issued = 0;
      m_row    = 0;
      q.delete();
    end else begin
      was_active = m_active;
      if (q.size() > 0 && q[0].due == cyc) begin
        m_row = q[0].data;
        if (q[0].last) m_active = 0;
        void'(q.pop_front());
      end
      if (was_active && m_issued < 4 && !bus.hold) begin
        item.due  = cyc + 2;
        item.data = modelAddr(m_x, m_y, m_issued);
        item.last = (m_issued == 3);
        q.push_back(item);
        m_issued++;
      end else if (!was_active && bus.start) begin
        m_active = 1;
        m_x      = int'(bus.blk_x);
        m_y      = int'(bus.blk_y);
        m_issued = 0;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    exp_rd   = m_active && (m_issued < 4) && !bus.hold;
    exp_addr = exp_rd ? modelAddr(m_x, m_y, m_issued) : 0;
    exp_en   = (q.size() > 0) && (q[0].due == cyc);
    exp_row  = exp_en ? q[0].data : m_row;
    exp_done = exp_en && q[0].last;
    checkOutput("mem_rd",   32'(bus.mem_rd),   32'(exp_rd));
    checkOutput("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
    checkOutput("out_en",   32'(bus.out_en),   32'(exp_en));
    checkOutput("out_row",  bus.out_row,       32'(exp_row));
    checkOutput("done",     32'(bus.done),     32'(exp_done));
    checkOutput("busy",     32'(bus.busy),     32'(m_active));
    if (bus.mem_rd === 1'b1) begin
      rd_log.push_back(cyc - t0);
      addr_log.push_back(int'(bus.mem_addr));
    end
    if (bus.out_en === 1'b1) begin
      en_log.push_back(cyc - t0);
      row_log.push_back(int'(bus.out_row));
    end
    if (bus.done === 1'b1) done_log.push_back(cyc - t0);
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_row", bus.out_row, 32'd0);

    // Basic fetch at (2,1).
    clearLogs();
    applyStimulus(1, 2, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (8) tick();
    e_a = '{66, 82, 98, 114}; e_b = '{1, 2, 3, 4}; e_c = '{3, 4, 5, 6}; e_d = '{6};
    checkList("basic_addr", addr_log, e_a);
    checkList("basic_rows", row_log, e_a);
    checkList("basic_rd_cyc", rd_log, e_b);
    checkList("basic_en_cyc", en_log, e_c);
    checkList("basic_done", done_log, e_d);

    // Address wrap past 4096.
    clearLogs();
    applyStimulus(1, 3, 64, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (8) tick();
    e_a = '{3, 19, 35, 51};
    checkList("wrap_addr", addr_log, e_a);
    checkList("wrap_rows", row_log, e_a);

    // Hold high in T+2..T+3.
    clearLogs();
    applyStimulus(1, 2, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1);
    repeat (2) tick();
    applyStimulus(0, 0, 0, 0);
    repeat (6) tick();
    e_a = '{66, 82, 98, 114}; e_b = '{1, 4, 5, 6}; e_c = '{3, 6, 7, 8}; e_d = '{8};
    checkList("hold_rd_cyc", rd_log, e_b);
    checkList("hold_en_cyc", en_log, e_c);
    checkList("hold_done", done_log, e_d);
    checkList("hold_rows", row_log, e_a);

    // Start pulse while busy must not disturb the fetch.
    clearLogs();
    applyStimulus(1, 2, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (2) tick();
    applyStimulus(1, 9, 5, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (5) tick();
    e_a = '{66, 82, 98, 114}; e_d = '{6};
    checkList("busy_start_addr", addr_log, e_a);
    checkList("busy_start_done", done_log, e_d);

    // Reset at T+3, restart at T+5.
    clearLogs();
    applyStimulus(1, 2, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_en", 32'(bus.out_en), 32'd0);
    checkOutput("midrst_rd", 32'(bus.mem_rd), 32'd0);
    checkOutput("midrst_row", bus.out_row, 32'd0);
    tick();
    applyStimulus(1, 2, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (7) tick();
    e_b = '{1, 2, 3, 6, 7, 8, 9}; e_c = '{3, 8, 9, 10, 11}; e_d = '{11};
    checkList("midrst_rd_cyc", rd_log, e_b);
    checkList("midrst_en_cyc", en_log, e_c);
    checkList("midrst_done", done_log, e_d);

    // Reset and start together: reset wins.
    rst = 1'b1;
    applyStimulus(1, 2, 1, 0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("collide_busy", 32'(bus.busy), 32'd0);
    checkOutput("collide_rd", 32'(bus.mem_rd), 32'd0);
    repeat (2) tick();

    // Start held high: accepted at T and again at T+7 only.
    clearLogs();
    applyStimulus(1, 2, 1, 0);
    repeat (8) tick();
    applyStimulus(0, 0, 0, 0);
    repeat (8) tick();
    e_b = '{1, 2, 3, 4, 8, 9, 10, 11}; e_c = '{3, 4, 5, 6, 10, 11, 12, 13}; e_d = '{6, 13};
    checkList("b2b_rd_cyc", rd_log, e_b);
    checkList("b2b_en_cyc", en_log, e_c);
    checkList("b2b_done", done_log, e_d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
